tdm_demux_4: RTL and testbench
==============================

Name: tdm_demux_4

Overview:
- Receiving end of a 4-channel time-division link.
- A 4:1 select-driven transmitter serializes four channel samples into one stream of slots 0..3. This block reassembles each frame of four slots into a parallel word.
- Slot 0 of every frame is marked by frame_sync. The block locks onto frame_sync, tracks the slot position with a counter, and flags framing errors.
- Sits between the serial link and downstream parallel logic, e.g. the full-adder operand registers.

Parameters:
- DATA_W, 1, width of one channel sample (bits per slot).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- serial_in  in  DATA_W  slot sample presented by the transmitter.
- in_valid  in  1  serial_in/frame_sync valid this cycle (one beat = one slot).
- frame_sync  in  1  qualified by in_valid; high marks slot 0 of a frame.
- data_out  out  4*DATA_W  reassembled frame; bits [DATA_W*(i+1)-1 : DATA_W*i] = slot i.
- out_valid  out  1  one-cycle pulse: data_out updated with a complete frame.
- locked  out  1  high while in LOCKED state.
- slot  out  2  slot index the next accepted beat will fill.
- sync_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- One clock domain. rst_n is asynchronous and active-low. All outputs are registered.
- Reset values:
  - state = HUNT.
  - slot = 0.
  - data_out = 0.
  - out_valid = 0, locked = 0, sync_err = 0.
  - Shadow registers sh[0..2] = 0.
- Reset mid-frame discards the partial frame. There is no output pulse on reset.
- A beat is accepted only when in_valid = 1. Cycles with in_valid = 0 change nothing except that the out_valid/sync_err pulses clear. Gaps of any length are allowed anywhere in a frame.
- State HUNT:
  - Beat with frame_sync = 0: discarded, no error.
  - Beat with frame_sync = 1: sh[0] <= serial_in, slot <= 1, state <= LOCKED, locked <= 1.
- State LOCKED, on an accepted beat:
  - slot = 0 and frame_sync = 1: sh[0] <= serial_in, slot <= 1.
  - slot in 1..2 and frame_sync = 0: sh[slot] <= serial_in, slot <= slot+1.
  - slot = 3 and frame_sync = 0: data_out <= {serial_in, sh[2], sh[1], sh[0]}, out_valid <= 1 for exactly one cycle, slot <= 0 (wrap).
  - frame_sync = 1 with slot != 0 (early sync): sync_err pulse; the partial frame is dropped with no out_valid; the beat is treated as slot 0, so sh[0] <= serial_in, slot <= 1; stay LOCKED.
  - frame_sync = 0 with slot = 0 (missing sync): sync_err pulse, beat discarded, state <= HUNT, locked <= 0, slot stays 0.
- Latency: data_out and out_valid are visible in the cycle after the clock edge that accepts the slot-3 beat.
- data_out holds its value until the next complete frame.
- Back-to-back frames with no gaps produce out_valid every 4th cycle.
- sh[] contents are don't-care after an error. They are never exposed except through a complete frame.

Test Plan:
- Reset, then 4 contiguous beats, DATA_W=1, serial_in = 1,0,1,1 with frame_sync on beat 0 -> 1 cycle after beat 3: data_out = 4'b1101, out_valid high 1 cycle, locked = 1, slot = 0.
- Beats before any frame_sync (3 beats, fs=0), then a valid frame 0,1,1,0 -> early beats ignored, no sync_err, data_out = 4'b0110.
- Same frame as above with in_valid low for 2 cycles between slots 1 and 2 -> identical data_out = 4'b0110. out_valid arrives 2 cycles later than the contiguous case. slot holds at 2 during the gap.
- frame_sync asserted on slot 2 -> sync_err pulse, no out_valid for the partial frame, slot = 1 next cycle. The following 3 beats 1,1,1 after a sync-beat value 0 -> data_out = 4'b1110.
- After a completed frame, next beat with frame_sync = 0 -> sync_err pulse, locked = 0, data_out unchanged. A subsequent valid frame relocks and delivers correctly.
- rst_n low for 1 cycle asynchronously after slot 2 -> all outputs 0 immediately. Remaining beat ignored (HUNT). The next full frame is output correctly.

Source files
------------

// File: rtl/tdm_demux_4.sv
// tdm_demux_4: receive side of a 4-slot TDM link.
// Locks onto frame_sync (which marks slot 0), tracks the slot position and
// collects slots 0..2 in shadow registers. On slot 3 it publishes the whole
// frame as one parallel word. Framing violations raise a one-cycle sync_err.
//
// Handshake: a beat is transferred on any rising edge where in_valid is high.
// There is no backpressure. out_valid is a one-cycle pulse and data_out holds
// its value until the next complete frame.
module tdm_demux_4 #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     serial_in,
  input  logic                  in_valid,
  input  logic                  frame_sync,
  output logic [4*DATA_W-1:0]   data_out,
  output logic                  out_valid,
  output logic                  locked,
  output logic [1:0]            slot,
  output logic                  sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q;
  logic [1:0]          slot_q;
  logic [DATA_W-1:0]   sh0_q, sh1_q, sh2_q;
  logic [4*DATA_W-1:0] data_q;
  logic                out_valid_q;
  logic                locked_q;
  logic                sync_err_q;

  // Framing FSM, slot counter, shadow capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= 2'd0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      // Both pulses clear on every cycle unless set again below.
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      if (in_valid) begin
        unique case (state_q)
          HUNT: begin
            // Beats that arrive before the first frame_sync are dropped silently.
            if (frame_sync) begin
              sh0_q    <= serial_in;
              slot_q   <= 2'd1;
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // A sync beat always starts a new frame. If it arrives early,
              // the partial frame is abandoned and an error is flagged.
              if (slot_q != 2'd0) sync_err_q <= 1'b1;
              sh0_q  <= serial_in;
              slot_q <= 2'd1;
            end else if (slot_q == 2'd0) begin
              // Sync is missing where slot 0 was due: lock is lost.
              sync_err_q <= 1'b1;
              state_q    <= HUNT;
              locked_q   <= 1'b0;
            end else if (slot_q == 2'd3) begin
              data_q      <= {serial_in, sh2_q, sh1_q, sh0_q};
              out_valid_q <= 1'b1;
              slot_q      <= 2'd0;
            end else begin
              if (slot_q == 2'd1) sh1_q <= serial_in;
              else                sh2_q <= serial_in;
              slot_q <= slot_q + 2'd1;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            slot_q   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign data_out  = data_q;
  assign out_valid = out_valid_q;
  assign locked    = locked_q;
  assign slot      = slot_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// tb_tdm_demux_4: directed and random frames for tdm_demux_4 (DATA_W = 1).
// Each expected frame word is pushed when its slot-3 beat is driven. A monitor
// pops and compares the word on every out_valid pulse.
module tb_tdm_demux_4;

  localparam int DATA_W = 1;
  localparam int W      = 4 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] serial_in = '0;
  logic              in_valid = 1'b0;
  logic              frame_sync = 1'b0;
  logic [W-1:0]      data_out;
  logic              out_valid;
  logic              locked;
  logic [1:0]        slot;
  logic              sync_err;

  tdm_demux_4 #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .in_valid   (in_valid),
    .frame_sync (frame_sync),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .locked     (locked),
    .slot       (slot),
    .sync_err   (sync_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives one beat across one rising edge and returns 1 time unit after that
  // edge. At that point the outputs reflect the accepted beat.
  task automatic beat(input logic si, input logic fs);
    serial_in  = si;
    frame_sync = fs;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends a full frame. s0 is carried by the sync beat. The expected word is
  // queued as the slot-3 beat is driven.
  task automatic frame(input logic s0, input logic s1, input logic s2, input logic s3);
    beat(s0, 1'b1);
    beat(s1, 1'b0);
    beat(s2, 1'b0);
    exp_q.push_back({s3, s2, s1, s0});
    beat(s3, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Compares each out_valid pulse against the queue, mid-cycle after the edge.
  always begin
    @(posedge clk);
    #2;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        check("frame_data", data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r;

    // Reset state.
    do_reset();
    check("rst_data_out", data_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_slot", slot, 0);
    check("rst_sync_err", sync_err, 0);

    // Basic frame 1,0,1,1 -> 4'b1101.
    frame(1'b1, 1'b0, 1'b1, 1'b1);
    check("t1_out_valid", out_valid, 1);
    check("t1_data", data_out, 4'b1101);
    check("t1_locked", locked, 1);
    check("t1_slot", slot, 0);
    idle(1);
    check("t1_pulse_clear", out_valid, 0);

    // Beats before any sync are ignored without error.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b0);
      check("t2_hunt_err", sync_err, 0);
      check("t2_hunt_locked", locked, 0);
    end
    frame(1'b0, 1'b1, 1'b1, 1'b0);
    check("t2_data", data_out, 4'b0110);

    // Same frame with a 2-cycle gap between slots 1 and 2.
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    idle(1);
    check("t3_gap_slot", slot, 2);
    idle(1);
    check("t3_gap_slot2", slot, 2);
    check("t3_gap_no_valid", out_valid, 0);
    beat(1'b1, 1'b0);
    exp_q.push_back(4'b0110);
    beat(1'b0, 1'b0);
    check("t3_out_valid", out_valid, 1);

    // Early sync on slot 2 drops the partial frame.
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    check("t4_sync_err", sync_err, 1);
    check("t4_no_valid", out_valid, 0);
    check("t4_slot", slot, 1);
    check("t4_locked", locked, 1);
    beat(1'b1, 1'b0);
    check("t4_err_clear", sync_err, 0);
    beat(1'b1, 1'b0);
    exp_q.push_back(4'b1110);
    beat(1'b1, 1'b0);
    check("t4_data", data_out, 4'b1110);

    // Missing sync after a completed frame loses lock; data_out holds.
    beat(1'b1, 1'b0);
    check("t5_sync_err", sync_err, 1);
    check("t5_locked", locked, 0);
    check("t5_slot", slot, 0);
    check("t5_data_hold", data_out, 4'b1110);
    frame(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_relock", locked, 1);
    check("t5_data", data_out, 4'b0011);

    // Asynchronous reset after slot 2.
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_data", data_out, 0);
    check("t6_async_locked", locked, 0);
    check("t6_async_slot", slot, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(1'b1, 1'b0);
    check("t6_hunt_err", sync_err, 0);
    check("t6_hunt_valid", out_valid, 0);
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_data", data_out, 4'b1000);

    // Back-to-back random frames: a pulse every 4th cycle.
    for (int k = 0; k < 8; k++) begin
      r = 4'($urandom_range(0, 15));
      frame(r[0], r[1], r[2], r[3]);
      check("rand_out_valid", out_valid, 1);
    end

    idle(3);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Time limit: the run must end on its own even if the stimulus stalls.
  initial begin
    #100000;
    $display("FAIL timeout: stimulus did not complete");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
